// File: rtl/float_alu_pkg.sv
// Shared FloatALU opcodes, sequencer state encoding and float constants.
package float_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MUL,
        S_ACC,
        S_DONE
    } state_t;

endpackage

// File: rtl/float_dot_seq_if.sv
// Bundle of job control, operand memory and FloatALU signals for float_dot_seq.
interface float_dot_seq_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] len;
    logic [31:0]       bias;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       x_data;
    logic [31:0]       w_data;
    logic [31:0]       alu_n1;
    logic [31:0]       alu_n2;
    logic [1:0]        alu_oper;
    logic [31:0]       alu_result;
    logic              alu_ovf;
    logic              alu_unf;
    logic              alu_exc;
    logic              busy;
    logic              done;
    logic [31:0]       result;
    logic              err;

    // Sequencer side
    modport slave (
        input  start, len, bias, x_data, w_data,
        input  alu_result, alu_ovf, alu_unf, alu_exc,
        output rd_en, rd_addr, alu_n1, alu_n2, alu_oper,
        output busy, done, result, err
    );

    // Layer controller / memory / ALU side
    modport master (
        output start, len, bias, x_data, w_data,
        output alu_result, alu_ovf, alu_unf, alu_exc,
        input  rd_en, rd_addr, alu_n1, alu_n2, alu_oper,
        input  busy, done, result, err
    );
endinterface

// File: rtl/float_dot_seq.sv
// Single-neuron dot-product sequencer: bias + sum(x[i]*w[i]) using one shared
// external FloatALU, alternating MUL and ADD, three cycles per term.
module float_dot_seq
    import float_alu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter bit RELU   = 1'b0
) (
    input logic            clk,
    input logic            rst,
    float_dot_seq_if.slave bus
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       acc;
    logic [31:0]       prod;
    logic [31:0]       result_q;
    logic              err_q;
    logic              last_term;
    logic              alu_flag;

    assign last_term = (idx == len_q - ADDR_W'(1));
    assign alu_flag  = bus.alu_ovf | bus.alu_unf | bus.alu_exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.alu_n1   = FP_ZERO;
        bus.alu_n2   = FP_ZERO;
        bus.alu_oper = OP_ADD;
        bus.busy     = (state != S_IDLE);
        bus.done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = idx;
                state_next  = S_MUL;
            end
            S_MUL: begin
                bus.alu_n1   = bus.x_data;
                bus.alu_n2   = bus.w_data;
                bus.alu_oper = OP_MUL;
                state_next   = S_ACC;
            end
            S_ACC: begin
                bus.alu_n1   = acc;
                bus.alu_n2   = prod;
                bus.alu_oper = OP_ADD;
                state_next   = last_term ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                bus.done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            idx      <= '0;
            acc      <= '0;
            prod     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q <= bus.len;
                        acc   <= bus.bias;
                        idx   <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_MUL: begin
                    prod  <= bus.alu_result;
                    err_q <= err_q | alu_flag;
                end
                S_ACC: begin
                    acc   <= bus.alu_result;
                    err_q <= err_q | alu_flag;
                    if (!last_term) begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    // Sign test also maps -0.0 to +0.0 under RELU
                    result_q <= (RELU && acc[31]) ? FP_ZERO : acc;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_float_dot_seq.sv
// Directed bench for float_dot_seq: two instances (RELU off/on) share stimulus,
// each with its own operand memory and behavioural FloatALU.
module tb_float_dot_seq;
    import float_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  len = '0;
    logic [31:0] bias = '0;
    logic [31:0] x_mem [0:15];
    logic [31:0] w_mem [0:15];
    int          n_checks = 0;
    int          n_fail = 0;
    int          rd_cnt = 0;
    int          dcyc;

    always #5 clk = ~clk;

    float_dot_seq_if #(.ADDR_W(10)) if0 ();
    float_dot_seq_if #(.ADDR_W(10)) if1 ();

    float_dot_seq #(.ADDR_W(10), .RELU(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    float_dot_seq #(.ADDR_W(10), .RELU(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    assign if0.start = start;
    assign if0.len   = len;
    assign if0.bias  = bias;
    assign if1.start = start;
    assign if1.len   = len;
    assign if1.bias  = bias;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        if (b[30:23] == 8'hFF) return b[31] ? -1.0e300 : 1.0e300;
        m = 1.0 + $itor({9'd0, b[22:0]}) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    // {ovf, unf, bits}
    function automatic logic [33:0] r2f(input real r);
        logic        s;
        real         a;
        int          e;
        logic [22:0] m;
        s = (r < 0.0);
        a = s ? -r : r;
        if (a == 0.0) return {2'b00, s, 31'd0};
        e = 127;
        while (a >= 2.0 && e <= 254) begin a = a / 2.0; e++; end
        while (a < 1.0 && e >= 1) begin a = a * 2.0; e--; end
        if (e > 254) return {2'b10, s, 8'hFF, 23'd0};
        if (e < 1) return {2'b01, s, 31'd0};
        m = 23'($rtoi((a - 1.0) * 8388608.0));
        return {2'b00, s, 8'(e), m};
    endfunction

    function automatic logic [33:0] alu(input logic [31:0] n1, input logic [31:0] n2,
                                        input logic [1:0] op);
        if (op == OP_MUL) return r2f(f2r(n1) * f2r(n2));
        if (op == OP_ADD) return r2f(f2r(n1) + f2r(n2));
        return 34'd0;
    endfunction

    always_comb begin
        {if0.alu_ovf, if0.alu_unf, if0.alu_result} = alu(if0.alu_n1, if0.alu_n2, if0.alu_oper);
        {if1.alu_ovf, if1.alu_unf, if1.alu_result} = alu(if1.alu_n1, if1.alu_n2, if1.alu_oper);
    end
    assign if0.alu_exc = 1'b0;
    assign if1.alu_exc = 1'b0;

    always @(posedge clk) begin
        if (if0.rd_en) begin
            if0.x_data <= x_mem[if0.rd_addr[3:0]];
            if0.w_data <= w_mem[if0.rd_addr[3:0]];
            rd_cnt     <= rd_cnt + 1;
        end
        if (if1.rd_en) begin
            if1.x_data <= x_mem[if1.rd_addr[3:0]];
            if1.w_data <= w_mem[if1.rd_addr[3:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept a job at edge 0, return the cycle in which done is seen (200 = timeout).
    task automatic run_job(input logic [9:0] l, input logic [31:0] b, input int repulse,
                           output int cyc);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        bias  = b;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        while (!if0.done && cyc < 200) begin
            if (cyc == repulse) begin
                start = 1'b1;
                len   = 10'd1;
                bias  = 32'h4120_0000;
            end
            @(posedge clk);
            #1 start = 1'b0;
            cyc++;
        end
        check_eq("done_relu_inst", {31'd0, if1.done}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", {31'd0, if0.done}, 32'd0);
    endtask

    initial begin
        int rd_before;
        int done_seen;
        for (int i = 0; i < 16; i++) begin
            x_mem[i] = '0;
            w_mem[i] = '0;
        end

        #2;
        check_eq("rst_busy", {31'd0, if0.busy}, 32'd0);
        check_eq("rst_done", {31'd0, if0.done}, 32'd0);
        check_eq("rst_rd_en", {31'd0, if0.rd_en}, 32'd0);
        check_eq("rst_rd_addr", {22'd0, if0.rd_addr}, 32'd0);
        check_eq("rst_result", if0.result, 32'd0);
        check_eq("rst_err", {31'd0, if0.err}, 32'd0);
        check_eq("rst_alu_n1", if0.alu_n1, 32'd0);
        check_eq("rst_alu_n2", if0.alu_n2, 32'd0);
        check_eq("rst_alu_oper", {30'd0, if0.alu_oper}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // 0.5 + 1*3 + 2*0.5 = 4.5
        x_mem[0] = 32'h3F80_0000; w_mem[0] = 32'h4040_0000;
        x_mem[1] = 32'h4000_0000; w_mem[1] = 32'h3F00_0000;
        run_job(10'd2, 32'h3F00_0000, 0, dcyc);
        check_eq("t1_done_cycle", dcyc, 32'd7);
        check_eq("t1_result", if0.result, 32'h4090_0000);
        check_eq("t1_result_relu", if1.result, 32'h4090_0000);
        check_eq("t1_err", {31'd0, if0.err}, 32'd0);
        check_eq("t1_busy_after", {31'd0, if0.busy}, 32'd0);

        rd_before = rd_cnt;
        run_job(10'd0, 32'h4040_0000, 0, dcyc);
        check_eq("t2_done_cycle", dcyc, 32'd1);
        check_eq("t2_result", if0.result, 32'h4040_0000);
        check_eq("t2_no_rd_en", rd_cnt - rd_before, 32'd0);

        // -1 * 2 = -2; RELU instance clamps to +0
        x_mem[0] = 32'hBF80_0000; w_mem[0] = 32'h4000_0000;
        run_job(10'd1, 32'h0000_0000, 0, dcyc);
        check_eq("t3_done_cycle", dcyc, 32'd4);
        check_eq("t3_result", if0.result, 32'hC000_0000);
        check_eq("t3_result_relu", if1.result, 32'h0000_0000);

        x_mem[0] = 32'h7F00_0000; w_mem[0] = 32'h7F00_0000;
        run_job(10'd1, 32'h0000_0000, 0, dcyc);
        check_eq("t4_err", {31'd0, if0.err}, 32'd1);
        check_eq("t4_err_relu", {31'd0, if1.err}, 32'd1);
        check_eq("t4_result_inf", if0.result, 32'h7F80_0000);

        // Restart in cycle 2 with different len/bias must be ignored
        x_mem[0] = 32'h3F80_0000; w_mem[0] = 32'h3F80_0000;
        x_mem[1] = 32'h4000_0000; w_mem[1] = 32'h3F80_0000;
        x_mem[2] = 32'h4040_0000; w_mem[2] = 32'h3F80_0000;
        run_job(10'd3, 32'h0000_0000, 2, dcyc);
        check_eq("t5_done_cycle", dcyc, 32'd10);
        check_eq("t5_result", if0.result, 32'h40C0_0000);
        check_eq("t5_err_clean", {31'd0, if0.err}, 32'd0);

        // Reset in cycle 5 of a new job
        @(negedge clk);
        start = 1'b1;
        len   = 10'd3;
        bias  = 32'h0000_0000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_eq("t6_busy_before_rst", {31'd0, if0.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_busy", {31'd0, if0.busy}, 32'd0);
        check_eq("t6_rst_result", if0.result, 32'd0);
        check_eq("t6_rst_done", {31'd0, if0.done}, 32'd0);
        check_eq("t6_rst_rd_en", {31'd0, if0.rd_en}, 32'd0);
        @(negedge clk) rst = 1'b0;
        done_seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (if0.done || if1.done) done_seen++;
        end
        check_eq("t6_no_done", done_seen, 32'd0);
        check_eq("t6_idle", {31'd0, if0.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/float_dot_seq.md
# float_dot_seq

Sequencer that computes one neuron's dot product, result = bias + Σ x[i]·w[i] for i = 0..len‑1, in IEEE‑754 single precision. It time‑multiplexes one externally instantiated FloatALU, alternating multiply and add operations. Operands are fetched from synchronous‑read activation/weight memories. It sits between the layer controller, which issues start/len/bias, and the shared float datapath.

## Interface
- `ADDR_W`, default 10: memory address width; max len = 2^ADDR_W − 1.
- `RELU`, default 0: 1 = clamp a negative final result to +0.0.

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active‑high reset
- `start`  in  1  begin a dot product; sampled only in IDLE
- `len`  in  ADDR_W  number of terms; latched on start
- `bias`  in  32  initial accumulator value; latched on start
- `rd_en`  out  1  memory read strobe
- `rd_addr`  out  ADDR_W  term index i
- `x_data`, `w_data`  in  32 each  memory read data, valid the cycle after rd_en
- `alu_n1`, `alu_n2`  out  32 each  FloatALU operands
- `alu_oper`  out  2  FloatALU opcode
- `alu_result`  in  32  FloatALU result, combinational from n1/n2/oper
- `alu_ovf`, `alu_unf`, `alu_exc`  in  1 each  FloatALU flags
- `busy`  out  1  high outside IDLE
- `done`  out  1  one‑cycle completion pulse
- `result`  out  32  final value; held until the next accepted start
- `err`  out  1  sticky OR of ALU flags for the current job

## Operation
- Opcodes: ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11. This block uses only ADD and MUL.
- States: IDLE, FETCH, MUL, ACC, DONE.
- **IDLE**
  - On start: latch len, set acc ← bias, idx ← 0, err ← 0.
  - If len == 0, go to DONE; otherwise go to FETCH.
- **FETCH**: rd_en = 1, rd_addr = idx. Go to MUL.
- **MUL**
  - Drive alu_n1 = x_data, alu_n2 = w_data, alu_oper = MUL.
  - prod ← alu_result; err |= any flag. Go to ACC.
- **ACC**
  - Drive alu_n1 = acc, alu_n2 = prod, alu_oper = ADD.
  - acc ← alu_result; err |= any flag.
  - If idx == len − 1, go to DONE. Otherwise idx ← idx + 1 and go to FETCH.
- **DONE**
  - done = 1 for this cycle.
  - result ← (RELU && acc[31]) ? 32'h0000_0000 : acc. This also clamps −0.0 to +0.0.
  - Go to IDLE.
- Saturated ALU outputs (±inf, 0, all‑ones) are accumulated as‑is. No retry is attempted.
- start while busy is ignored. len and bias changes after acceptance have no effect.
- Outside MUL/ACC: alu_n1 = alu_n2 = 0, alu_oper = ADD.

## Timing
- All registers reset asynchronously. Reset values:
  - state = IDLE
  - rd_en = 0, rd_addr = 0, busy = 0, done = 0
  - result = 0, err = 0
  - alu_n1 = alu_n2 = 0, alu_oper = 2'b00
- alu_n1, alu_n2 and alu_oper are decoded from state and registers. rd_en and rd_addr are decoded from state and idx.
- Let start be accepted at edge 0. Then done is high in cycle 3·len + 1 (len == 0 → cycle 1). result and err are updated at the end of that cycle.
- Throughput: 3 cycles per term plus 2 cycles of overhead per job. The earliest next start is accepted in the cycle after done.
- Reset asserted mid‑job: immediate return to IDLE, no done pulse, result cleared.

## Structure
- Package `float_alu_pkg` holds:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`
  - the state encoding
  - float constants `FP_ZERO` and `FP_ONE`
- No sub‑module. The FloatALU is instantiated by the parent so other controllers can share it through an external mux.

## Test plan
- len = 2, x = {3F800000, 40000000}, w = {40400000, 3F000000}, bias = 3F000000 → result = 40900000 (4.5), done in cycle 7, err = 0.
- len = 0, bias = 40400000 → done in cycle 1, result = 40400000, rd_en never asserted.
- len = 1, x = BF800000, w = 40000000, bias = 0:
  - RELU = 0 → result = C0000000.
  - RELU = 1 → result = 00000000.
- len = 1, x = w = 7F000000 → err = 1 at done. The next job with clean data has err = 0.
- start pulsed again in cycle 2 of a len = 3 job → ignored, done only in cycle 10. Then rst asserted in cycle 5 of a new job → state = IDLE, busy = 0, result = 0, no done pulse.
